// File: rtl/uart_alu_ctrl.sv
// Frame sequencer between UART and ALU: collects operand A, operand B and opcode,
// runs the ALU for one cycle, then sends the result back as a single UART byte.
module uart_alu_ctrl #(
  parameter int N_DATA         = 8,
  parameter int N_OP           = 6,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_rx_done,
  input  logic [N_DATA-1:0] i_rx_data,
  input  logic              i_tx_done,
  output logic              o_tx_signal,
  output logic [N_DATA-1:0] o_tx_result,
  output logic [N_DATA-1:0] o_alu_a,
  output logic [N_DATA-1:0] o_alu_b,
  output logic [N_OP-1:0]   o_alu_op,
  input  logic [N_DATA-1:0] i_alu_result,
  output logic              o_busy,
  output logic              o_err_op,
  output logic              o_err_timeout,
  output logic              o_err_overrun
);

  localparam logic [2:0] WAIT_A  = 3'd0;
  localparam logic [2:0] WAIT_B  = 3'd1;
  localparam logic [2:0] WAIT_OP = 3'd2;
  localparam logic [2:0] EXEC    = 3'd3;
  localparam logic [2:0] SEND    = 3'd4;
  localparam logic [2:0] WAIT_TX = 3'd5;

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [N_OP-1:0] OP_ADD = N_OP'('h20);
  localparam logic [N_OP-1:0] OP_SUB = N_OP'('h22);
  localparam logic [N_OP-1:0] OP_AND = N_OP'('h24);
  localparam logic [N_OP-1:0] OP_OR  = N_OP'('h25);
  localparam logic [N_OP-1:0] OP_XOR = N_OP'('h26);
  localparam logic [N_OP-1:0] OP_NOR = N_OP'('h27);
  localparam logic [N_OP-1:0] OP_SRA = N_OP'('h03);
  localparam logic [N_OP-1:0] OP_SRL = N_OP'('h02);

  logic [2:0]        r_state;
  logic [2:0]        w_state_nx;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt_nx;
  logic [N_DATA-1:0] r_alu_a;
  logic [N_DATA-1:0] r_alu_b;
  logic [N_DATA-1:0] r_tx_result;
  logic [N_OP-1:0]   r_alu_op;
  logic              r_tx_signal;
  logic              r_busy;
  logic              r_err_op;
  logic              r_err_timeout;
  logic              r_err_overrun;
  logic              w_op_valid;
  logic              w_timeout;
  logic              w_err_op;
  logic              w_err_overrun;

  always_comb begin
    w_op_valid = 1'b0;
    if (i_rx_data[N_DATA-1:N_OP] == '0) begin
      case (i_rx_data[N_OP-1:0])
        OP_ADD, OP_SUB, OP_AND, OP_OR,
        OP_XOR, OP_NOR, OP_SRA, OP_SRL: w_op_valid = 1'b1;
        default:                        w_op_valid = 1'b0;
      endcase
    end
  end

  // A byte arriving on the terminal count wins over the timeout.
  always_comb begin
    w_state_nx    = r_state;
    w_cnt_nx      = r_cnt + CW'(1);
    w_timeout     = 1'b0;
    w_err_op      = 1'b0;
    w_err_overrun = 1'b0;
    case (r_state)
      WAIT_A: begin
        w_cnt_nx = '0;
        if (i_rx_done) w_state_nx = WAIT_B;
      end
      WAIT_B: begin
        if (i_rx_done) begin
          w_cnt_nx   = '0;
          w_state_nx = WAIT_OP;
        end else if (r_cnt == TERM) begin
          w_cnt_nx   = '0;
          w_timeout  = 1'b1;
          w_state_nx = WAIT_A;
        end
      end
      WAIT_OP: begin
        if (i_rx_done) begin
          w_cnt_nx = '0;
          if (w_op_valid) begin
            w_state_nx = EXEC;
          end else begin
            w_err_op   = 1'b1;
            w_state_nx = WAIT_A;
          end
        end else if (r_cnt == TERM) begin
          w_cnt_nx   = '0;
          w_timeout  = 1'b1;
          w_state_nx = WAIT_A;
        end
      end
      EXEC: begin
        w_cnt_nx      = '0;
        w_err_overrun = i_rx_done;
        w_state_nx    = SEND;
      end
      SEND: begin
        w_cnt_nx      = '0;
        w_err_overrun = i_rx_done;
        w_state_nx    = WAIT_TX;
      end
      WAIT_TX: begin
        w_cnt_nx      = '0;
        w_err_overrun = i_rx_done;
        if (i_tx_done) w_state_nx = WAIT_A;
      end
      default: begin
        w_cnt_nx   = '0;
        w_state_nx = WAIT_A;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state       <= WAIT_A;
      r_cnt         <= '0;
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_op      <= '0;
      r_tx_result   <= '0;
      r_tx_signal   <= 1'b0;
      r_busy        <= 1'b0;
      r_err_op      <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_overrun <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      if (r_state == WAIT_A && i_rx_done) r_alu_a <= i_rx_data;
      if (r_state == WAIT_B && i_rx_done) r_alu_b <= i_rx_data;
      if (r_state == WAIT_OP && i_rx_done && w_op_valid) r_alu_op <= i_rx_data[N_OP-1:0];
      if (r_state == EXEC) r_tx_result <= i_alu_result;
      r_tx_signal   <= (r_state == EXEC);
      r_busy        <= (w_state_nx == EXEC) || (w_state_nx == SEND) || (w_state_nx == WAIT_TX);
      r_err_op      <= w_err_op;
      r_err_timeout <= w_timeout;
      r_err_overrun <= w_err_overrun;
    end
  end

  assign o_tx_signal   = r_tx_signal;
  assign o_tx_result   = r_tx_result;
  assign o_alu_a       = r_alu_a;
  assign o_alu_b       = r_alu_b;
  assign o_alu_op      = r_alu_op;
  assign o_busy        = r_busy;
  assign o_err_op      = r_err_op;
  assign o_err_timeout = r_err_timeout;
  assign o_err_overrun = r_err_overrun;

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Bench for uart_alu_ctrl: vector table, hand-written corner sequences and
// randomized frames checked against a frame-level reference model.
module tb_uart_alu_ctrl;

  logic       clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_rx_done = 1'b0;
  logic [7:0] i_rx_data = '0;
  logic       i_tx_done = 1'b0;
  logic       o_tx_signal;
  logic [7:0] o_tx_result;
  logic [7:0] o_alu_a;
  logic [7:0] o_alu_b;
  logic [5:0] o_alu_op;
  logic [7:0] i_alu_result;
  logic       o_busy;
  logic       o_err_op;
  logic       o_err_timeout;
  logic       o_err_overrun;

  int errors = 0;
  int checks = 0;
  logic [5:0] exp_op = '0;

  uart_alu_ctrl #(.N_DATA(8), .N_OP(6), .TIMEOUT_CYCLES(100)) dut (
    .i_clock(clk), .i_reset(i_reset), .i_rx_done(i_rx_done), .i_rx_data(i_rx_data),
    .i_tx_done(i_tx_done), .o_tx_signal(o_tx_signal), .o_tx_result(o_tx_result),
    .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_op(o_alu_op),
    .i_alu_result(i_alu_result), .o_busy(o_busy), .o_err_op(o_err_op),
    .o_err_timeout(o_err_timeout), .o_err_overrun(o_err_overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    case (op)
      6'h20: return a + b;
      6'h22: return a - b;
      6'h24: return a & b;
      6'h25: return a | b;
      6'h26: return a ^ b;
      6'h27: return ~(a | b);
      6'h03: return 8'($signed(a) >>> b);
      6'h02: return a >> b;
      default: return 8'h00;
    endcase
  endfunction

  function automatic bit op_ok(input logic [7:0] op);
    logic [7:0] legal [8] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};
    foreach (legal[k]) if (legal[k] == op) return 1'b1;
    return 1'b0;
  endfunction

  // Environment ALU: combinational on the DUT's latched operands.
  always_comb i_alu_result = alu(o_alu_a, o_alu_b, o_alu_op);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_done = 1'b1;
    i_rx_data = b;
    tick;
    i_rx_done = 1'b0;
  endtask

  task automatic do_reset;
    i_reset = 1'b1;
    tick;
    i_reset = 1'b0;
    exp_op = '0;
  endtask

  task automatic check_zero_outputs(input string name);
    check(name, {o_alu_a, o_alu_b, 2'b00, o_alu_op, o_tx_result}, 32'h0);
    check({name, "_flags"}, {o_tx_signal, o_busy, o_err_op, o_err_timeout, o_err_overrun}, 5'b0);
  endtask

  task automatic finish_tx(input logic [7:0] res, input int gap);
    check("exec_flags", {o_busy, o_tx_signal, o_err_op}, 3'b100);
    check("alu_op", o_alu_op, exp_op);
    tick;
    check("send_pulse", {o_tx_signal, o_busy}, 2'b11);
    check("tx_result", o_tx_result, res);
    tick;
    check("pulse_width", {o_tx_signal, o_busy}, 2'b01);
    idle(gap);
    check("wait_tx_busy", o_busy, 1'b1);
    i_tx_done = 1'b1;
    tick;
    i_tx_done = 1'b0;
    check("tx_done_idle", o_busy, 1'b0);
  endtask

  task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                           input bit valid, input logic [7:0] res, input int gap);
    send_byte(a);
    check("alu_a", o_alu_a, a);
    idle(gap);
    send_byte(b);
    check("alu_b", o_alu_b, b);
    idle(gap);
    send_byte(op);
    if (valid) begin
      exp_op = op[5:0];
      finish_tx(res, gap);
    end else begin
      check("err_op", {o_err_op, o_busy, o_tx_signal, o_err_timeout}, 4'b1000);
      check("op_kept", o_alu_op, exp_op);
      tick;
      check("err_op_width", {o_err_op, o_tx_signal}, 2'b00);
    end
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] op;
    bit         valid;
    logic [7:0] res;
  } vec_t;

  vec_t vecs [$];

  initial begin
    int hits;
    vecs.push_back('{8'h05, 8'h03, 8'h20, 1'b1, 8'h08});
    vecs.push_back('{8'h0A, 8'h01, 8'h3F, 1'b0, 8'h00});
    vecs.push_back('{8'h04, 8'h04, 8'h20, 1'b1, 8'h08});
    vecs.push_back('{8'h10, 8'h03, 8'h22, 1'b1, 8'h0D});
    vecs.push_back('{8'hF0, 8'h3C, 8'h24, 1'b1, 8'h30});
    vecs.push_back('{8'hF0, 8'h0F, 8'h25, 1'b1, 8'hFF});
    vecs.push_back('{8'hFF, 8'h0F, 8'h26, 1'b1, 8'hF0});
    vecs.push_back('{8'hF0, 8'h0F, 8'h27, 1'b1, 8'h00});
    vecs.push_back('{8'h80, 8'h02, 8'h03, 1'b1, 8'hE0});
    vecs.push_back('{8'h80, 8'h02, 8'h02, 1'b1, 8'h20});
    vecs.push_back('{8'h12, 8'h34, 8'h60, 1'b0, 8'h00});
    vecs.push_back('{8'h00, 8'h00, 8'h21, 1'b0, 8'h00});

    tick;
    do_reset;
    check_zero_outputs("reset");

    foreach (vecs[k]) run_frame(vecs[k].a, vecs[k].b, vecs[k].op, vecs[k].valid, vecs[k].res, k % 3);

    // Timeout after operand A: pulse lands on the 100th edge after the accept.
    send_byte(8'h11);
    hits = 0;
    for (int i = 0; i < 99; i++) begin
      tick;
      if (o_err_timeout) hits++;
    end
    check("timeout_early", hits, 0);
    tick;
    check("timeout_pulse", {o_err_timeout, o_err_op, o_err_overrun, o_busy}, 4'b1000);
    tick;
    check("timeout_width", o_err_timeout, 1'b0);
    send_byte(8'h22);
    check("after_timeout_a", o_alu_a, 8'h22);
    check("after_timeout_b_kept", o_alu_b, 8'h00);
    send_byte(8'h01);
    send_byte(8'h20);
    exp_op = 6'h20;
    finish_tx(8'h23, 0);

    // Overrun during EXEC and during WAIT_TX.
    run_frame(8'h07, 8'h02, 8'h22, 1'b1, 8'h05, 0);
    send_byte(8'h09);
    send_byte(8'h06);
    send_byte(8'h26);
    exp_op = 6'h26;
    send_byte(8'h99);
    check("overrun_exec", {o_err_overrun, o_tx_signal, o_err_op}, 3'b110);
    check("overrun_exec_a", o_alu_a, 8'h09);
    tick;
    check("overrun_width", {o_err_overrun, o_tx_signal, o_busy}, 3'b001);
    send_byte(8'h55);
    check("overrun_waittx", {o_err_overrun, o_busy}, 2'b11);
    check("overrun_regs", {o_alu_a, o_alu_b, o_tx_result}, {8'h09, 8'h06, 8'h0F});
    tick;
    check("overrun_width2", o_err_overrun, 1'b0);
    i_tx_done = 1'b1;
    tick;
    i_tx_done = 1'b0;
    check("overrun_tx_done", o_busy, 1'b0);

    // Reset in WAIT_OP, then a full AND frame.
    send_byte(8'h01);
    send_byte(8'h02);
    do_reset;
    check_zero_outputs("mid_reset");
    run_frame(8'hF0, 8'h0F, 8'h24, 1'b1, 8'h00, 1);

    // Operand B arrives exactly on the terminal count.
    send_byte(8'h33);
    idle(99);
    send_byte(8'h44);
    check("terminal_accept", {o_err_timeout, o_alu_b}, {1'b0, 8'h44});
    tick;
    check("terminal_no_late", o_err_timeout, 1'b0);
    send_byte(8'h20);
    exp_op = 6'h20;
    finish_tx(8'h77, 0);

    // Randomized frames against the frame-level model.
    for (int i = 0; i < 40; i++) begin
      logic [7:0] ra, rb, rop;
      logic [7:0] legal [8] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};
      ra = 8'($urandom);
      rb = 8'($urandom);
      if ($urandom_range(3) != 0) rop = legal[$urandom_range(7)];
      else rop = 8'($urandom);
      run_frame(ra, rb, rop, op_ok(rop), alu(ra, rb, rop[5:0]), int'($urandom_range(4)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
